// File: rtl/axi_rd_vc_ctrl_pkg.sv
// Shared types for the NI read-side controller: AXI burst/resp encodings, OT entry, FSM states.
// Combinational helper only; no state.
package axi_rd_vc_ctrl_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } aerror_t;

  // Field widths are upper bounds; instances use the low ID_W / VC_W bits.
  localparam int OT_ID_W = 8;
  localparam int OT_VC_W = 8;

  typedef struct packed {
    logic [OT_ID_W-1:0] id;
    logic [7:0]         len;
    logic [OT_VC_W-1:0] vc;
    logic               err;
  } s_ot_rd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    ERR  = 2'b10
  } rd_fsm_t;

  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == FIXED) || (burst == INCR);
  endfunction

endpackage

// File: rtl/axi_rd_vc_ctrl_if.sv
// AXI AR/R channels, packet-receiver flit port and per-VC IRQs of the NI read side.
// Slave modport is the controller; master modport is its environment.
interface axi_rd_vc_ctrl_if #(
  parameter int N_VC   = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int VC_W   = 2
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [1:0]        ar_burst;
  logic [ID_W-1:0]   ar_id;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [ID_W-1:0]   r_id;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [VC_W-1:0]   pkt_vc;
  logic [DATA_W-1:0] pkt_data;

  logic [N_VC-1:0]   irq_vc;

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_burst, ar_id, r_ready, pkt_valid, pkt_vc, pkt_data,
    output ar_ready, r_valid, r_data, r_resp, r_last, r_id, pkt_ready, irq_vc
  );

  modport master (
    output ar_valid, ar_addr, ar_len, ar_burst, ar_id, r_ready, pkt_valid, pkt_vc, pkt_data,
    input  ar_ready, r_valid, r_data, r_resp, r_last, r_id, pkt_ready, irq_vc
  );
endinterface

// File: rtl/fifo.sv
// Generic registered FIFO, any DEPTH >= 1.
// Data readable the cycle after push; push ignored when full, pop ignored when empty.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en, rd_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
      else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/ni_vc_fifo.sv
// Per-VC flit buffer (power-of-2 DEPTH) exposing occupancy for the IRQ logic.
// Flit readable the cycle after push; push dropped when full, so callers gate on full_o.
module ni_vc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [OCC_W-1:0] occ_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      diff;
  logic             wr_en, rd_en;

  // Extra MSB on the pointers separates full from empty without a counter.
  assign diff    = wr_ptr_q - rd_ptr_q;
  assign occ_o   = OCC_W'(diff);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/axi_rd_vc_ctrl.sv
// NI read side: buffers receiver flits per VC and serves them as AXI read bursts (SLVERR on decode error/timeout).
// First beat 2 cycles after AR; ar_ready drops when MAX_OT_RD bursts queued; pkt_ready drops when the target VC is full.
module axi_rd_vc_ctrl
  import axi_rd_vc_ctrl_pkg::*;
#(
  parameter int              N_VC          = 4,
  parameter int              DATA_W        = 64,
  parameter int              ADDR_W        = 32,
  parameter int              ID_W          = 4,
  parameter int              VC_DEPTH      = 8,
  parameter int              MAX_OT_RD     = 4,
  parameter logic [ADDR_W-1:0] RD_BASE     = 'h2000,
  parameter int              IRQ_THRESHOLD = 1,
  parameter int              TIMEOUT_CYC   = 0,
  localparam int             VC_W          = (N_VC > 1) ? $clog2(N_VC) : 1,
  localparam int             OCC_W         = $clog2(VC_DEPTH + 1),
  localparam int             TO_W          = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input logic              clk_axi,
  input logic              arst_axi,
  axi_rd_vc_ctrl_if.slave  bus
);
  logic [8:0]        ar_idx;
  logic              ar_err, ar_hs;
  s_ot_rd_t          ot_in, ot_head;
  logic              ot_full, ot_empty, ot_pop;
  logic [VC_W-1:0]   hvc;
  logic              unused_ot;

  logic [N_VC-1:0]   vc_full, vc_empty, vc_push, vc_pop;
  logic [DATA_W-1:0] vc_dat [N_VC];
  logic [OCC_W-1:0]  vc_occ [N_VC];
  logic              vc_pop_en;

  rd_fsm_t           state_q, state_d;
  logic [7:0]        beat_q, beat_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic              r_valid_c, r_last_c;
  logic [1:0]        r_resp_c;
  logic [DATA_W-1:0] r_data_c;
  logic [ID_W-1:0]   r_id_c;

  assign ar_idx = bus.ar_addr[11:3];
  assign ar_err = (bus.ar_addr[ADDR_W-1:12] != RD_BASE[ADDR_W-1:12])
               || (bus.ar_addr[2:0] != 3'd0)
               || (32'(ar_idx) >= 32'(N_VC))
               || !burst_supported(bus.ar_burst);
  assign ar_hs  = bus.ar_valid && !ot_full;
  assign bus.ar_ready = !ot_full;

  // Error entries carry vc=0 so the head never indexes a nonexistent VC.
  always_comb begin
    ot_in                = '0;
    ot_in.id[ID_W-1:0]   = bus.ar_id;
    ot_in.len            = bus.ar_len;
    ot_in.vc[VC_W-1:0]   = ar_err ? '0 : ar_idx[VC_W-1:0];
    ot_in.err            = ar_err;
  end

  fifo #(
    .WIDTH ($bits(s_ot_rd_t)),
    .DEPTH (MAX_OT_RD)
  ) u_ot (
    .clk_i   (clk_axi),
    .arst_ni (arst_axi),
    .push_i  (ar_hs),
    .data_i  (ot_in),
    .pop_i   (ot_pop),
    .data_o  (ot_head),
    .full_o  (ot_full),
    .empty_o (ot_empty)
  );

  assign hvc       = ot_head.vc[VC_W-1:0];
  assign unused_ot = ^ot_head;

  assign bus.pkt_ready = !vc_full[bus.pkt_vc];

  for (genvar i = 0; i < N_VC; i++) begin : g_vc
    assign vc_push[i] = bus.pkt_valid && bus.pkt_ready && (bus.pkt_vc == VC_W'(i));

    ni_vc_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (VC_DEPTH)
    ) u_vc_fifo (
      .clk_i   (clk_axi),
      .arst_ni (arst_axi),
      .push_i  (vc_push[i]),
      .data_i  (bus.pkt_data),
      .pop_i   (vc_pop[i]),
      .data_o  (vc_dat[i]),
      .full_o  (vc_full[i]),
      .empty_o (vc_empty[i]),
      .occ_o   (vc_occ[i])
    );

    assign bus.irq_vc[i] = (vc_occ[i] >= OCC_W'(IRQ_THRESHOLD));
  end

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      state_q <= IDLE;
      beat_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    to_d      = to_q;
    ot_pop    = 1'b0;
    vc_pop_en = 1'b0;
    r_valid_c = 1'b0;
    r_last_c  = 1'b0;
    r_resp_c  = OKAY;
    r_data_c  = '0;
    r_id_c    = '0;
    unique case (state_q)
      IDLE: begin
        if (!ot_empty) begin
          state_d = ot_head.err ? ERR : DATA;
          beat_d  = '0;
          to_d    = '0;
        end
      end
      DATA: begin
        r_valid_c = !vc_empty[hvc];
        r_id_c    = ot_head.id[ID_W-1:0];
        r_last_c  = r_valid_c && (beat_q == ot_head.len);
        r_data_c  = r_valid_c ? vc_dat[hvc] : '0;
        if (r_valid_c && bus.r_ready) begin
          vc_pop_en = 1'b1;
          to_d      = '0;
          if (r_last_c) begin
            ot_pop  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else if (!r_valid_c && (TIMEOUT_CYC != 0)) begin
          // Abort keeps beat_q so ERR completes exactly the beats still owed.
          if (to_q == TO_W'(TIMEOUT_CYC)) state_d = ERR;
          else                            to_d    = to_q + 1'b1;
        end
      end
      ERR: begin
        r_valid_c = 1'b1;
        r_resp_c  = SLVERR;
        r_id_c    = ot_head.id[ID_W-1:0];
        r_last_c  = (beat_q == ot_head.len);
        if (bus.r_ready) begin
          if (r_last_c) begin
            ot_pop  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vc_pop = '0;
    if (vc_pop_en) vc_pop[hvc] = 1'b1;
  end

  assign bus.r_valid = r_valid_c;
  assign bus.r_last  = r_last_c;
  assign bus.r_resp  = r_resp_c;
  assign bus.r_data  = r_data_c;
  assign bus.r_id    = r_id_c;
endmodule

// File: tb/tb_axi_rd_vc_ctrl.sv
// Directed bench for axi_rd_vc_ctrl with TIMEOUT_CYC=16, IRQ_THRESHOLD=4, VC_DEPTH=8, MAX_OT_RD=4.
module tb_axi_rd_vc_ctrl;
  import axi_rd_vc_ctrl_pkg::*;

  localparam int          N_VC    = 4;
  localparam int          DATA_W  = 64;
  localparam int          ADDR_W  = 32;
  localparam int          ID_W    = 4;
  localparam int          VC_W    = 2;
  localparam logic [31:0] RD_BASE = 32'h2000;

  logic clk_axi  = 1'b0;
  logic arst_axi = 1'b0;
  int   n_chk    = 0;
  int   n_fail   = 0;

  always #5 clk_axi = ~clk_axi;

  axi_rd_vc_ctrl_if #(
    .N_VC(N_VC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .VC_W(VC_W)
  ) bus ();

  axi_rd_vc_ctrl #(
    .N_VC(N_VC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
    .VC_DEPTH(8), .MAX_OT_RD(4), .RD_BASE(RD_BASE),
    .IRQ_THRESHOLD(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk_axi  (clk_axi),
    .arst_axi (arst_axi),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_axi);
    #1;
  endtask

  task automatic exp_r(input string tag, input logic v, input logic [63:0] d,
                       input logic [1:0] resp, input logic last, input logic [3:0] id);
    chk({tag, ".r_valid"}, 64'(bus.r_valid), 64'(v));
    chk({tag, ".r_data"},  bus.r_data, d);
    chk({tag, ".r_last"},  64'(bus.r_last), 64'(last));
    if (v) begin
      chk({tag, ".r_resp"}, 64'(bus.r_resp), 64'(resp));
      chk({tag, ".r_id"},   64'(bus.r_id),   64'(id));
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [63:0] d,
                      input logic [1:0] resp, input logic last, input logic [3:0] id);
    #1;
    exp_r(tag, v, d, resp, last, id);
    cyc();
  endtask

  task automatic push_flit(input logic [1:0] vc, input logic [63:0] d);
    bus.pkt_valid = 1'b1;
    bus.pkt_vc    = vc;
    bus.pkt_data  = d;
    #1;
    chk("push.pkt_ready", 64'(bus.pkt_ready), 64'd1);
    cyc();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = addr;
    bus.ar_len   = len;
    bus.ar_burst = burst;
    bus.ar_id    = id;
    #1;
    chk("ar.ar_ready", 64'(bus.ar_ready), 64'd1);
    cyc();
    bus.ar_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ar_ready"},  64'(bus.ar_ready),  64'd1);
    chk({tag, ".pkt_ready"}, 64'(bus.pkt_ready), 64'd1);
    chk({tag, ".irq_vc"},    64'(bus.irq_vc),    64'd0);
    chk({tag, ".r_resp"},    64'(bus.r_resp),    64'd0);
    chk({tag, ".r_id"},      64'(bus.r_id),      64'd0);
    exp_r(tag, 1'b0, 64'd0, OKAY, 1'b0, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ar_valid  = 1'b0;
    bus.ar_addr   = '0;
    bus.ar_len    = '0;
    bus.ar_burst  = '0;
    bus.ar_id     = '0;
    bus.r_ready   = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.pkt_vc    = '0;
    bus.pkt_data  = '0;

    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk_axi);
    #2 arst_axi = 1'b1;
    cyc();

    // Valid INCR burst from pre-buffered VC2
    bus.r_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_flit(2'd2, 64'hA0 + 64'(k));
    send_ar(RD_BASE + 32'h10, 8'd2, INCR, 4'd5);
    step("t1.gap",   1'b0, 64'd0,  OKAY, 1'b0, 4'd0);
    step("t1.beat0", 1'b1, 64'hA0, OKAY, 1'b0, 4'd5);
    step("t1.beat1", 1'b1, 64'hA1, OKAY, 1'b0, 4'd5);
    step("t1.beat2", 1'b1, 64'hA2, OKAY, 1'b1, 4'd5);
    step("t1.after", 1'b0, 64'd0,  OKAY, 1'b0, 4'd0);

    // Misaligned address -> 4 SLVERR beats, then a valid burst after one bubble
    push_flit(2'd0, 64'hB0);
    send_ar(RD_BASE + 32'h04, 8'd3, INCR, 4'd3);
    send_ar(RD_BASE,          8'd0, INCR, 4'd7);
    for (int k = 0; k < 4; k++) step("t2.err", 1'b1, 64'd0, SLVERR, k == 3, 4'd3);
    step("t2.bubble", 1'b0, 64'd0,  OKAY, 1'b0, 4'd0);
    step("t2.ok",     1'b1, 64'hB0, OKAY, 1'b1, 4'd7);
    step("t2.after",  1'b0, 64'd0,  OKAY, 1'b0, 4'd0);

    // WRAP burst is unsupported -> single SLVERR beat, queue drains
    send_ar(RD_BASE + 32'h08, 8'd0, WRAP, 4'd2);
    step("t3.gap",   1'b0, 64'd0, OKAY,   1'b0, 4'd0);
    step("t3.err",   1'b1, 64'd0, SLVERR, 1'b1, 4'd2);
    step("t3.idle0", 1'b0, 64'd0, OKAY,   1'b0, 4'd0);
    step("t3.idle1", 1'b0, 64'd0, OKAY,   1'b0, 4'd0);

    // Outstanding limit: 4 accepted, 5th stalls until the first burst completes
    bus.r_ready  = 1'b0;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = RD_BASE;
    bus.ar_len   = 8'd0;
    bus.ar_burst = WRAP;
    for (int k = 1; k <= 5; k++) begin
      bus.ar_id = 4'(k);
      #1;
      chk((k <= 4) ? "t4.ar_ready_open" : "t4.ar_ready_full", 64'(bus.ar_ready), (k <= 4) ? 64'd1 : 64'd0);
      cyc();
    end
    bus.r_ready = 1'b1;
    #1;
    chk("t4.ar_ready_still_full", 64'(bus.ar_ready), 64'd0);
    exp_r("t4.held", 1'b1, 64'd0, SLVERR, 1'b1, 4'd1);
    cyc();
    #1;
    chk("t4.ar_ready_reopen", 64'(bus.ar_ready), 64'd1);
    exp_r("t4.bubble", 1'b0, 64'd0, OKAY, 1'b0, 4'd0);
    cyc();
    bus.ar_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step("t4.drain", 1'b1, 64'd0, SLVERR, 1'b1, 4'(k));
      step("t4.gap",   1'b0, 64'd0, OKAY,   1'b0, 4'd0);
    end

    // Empty-VC timeout aborts the remaining beats with SLVERR
    push_flit(2'd0, 64'hC0);
    send_ar(RD_BASE, 8'd3, INCR, 4'd9);
    step("t5.gap",  1'b0, 64'd0,  OKAY, 1'b0, 4'd0);
    step("t5.ok",   1'b1, 64'hC0, OKAY, 1'b0, 4'd9);
    for (int k = 1; k <= 17; k++) step("t5.wait", 1'b0, 64'd0, OKAY, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) step("t5.abort", 1'b1, 64'd0, SLVERR, k == 2, 4'd9);
    step("t5.after", 1'b0, 64'd0, OKAY, 1'b0, 4'd0);

    // Occupancy IRQ, full VC backpressure, push+pop balance, reset mid-burst
    bus.r_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.pkt_valid = 1'b1;
      bus.pkt_vc    = 2'd1;
      bus.pkt_data  = 64'hD0 + 64'(k);
      #1;
      chk("t6.pkt_ready_fill", 64'(bus.pkt_ready), 64'd1);
      cyc();
      #1;
      chk("t6.irq_fill", 64'(bus.irq_vc), (k >= 3) ? 64'h2 : 64'h0);
    end
    bus.pkt_data = 64'hD8;
    #1;
    chk("t6.pkt_ready_full", 64'(bus.pkt_ready), 64'd0);
    send_ar(RD_BASE + 32'h08, 8'd7, INCR, 4'd4);
    step("t6.gap", 1'b0, 64'd0, OKAY, 1'b0, 4'd0);
    step("t6.stall0", 1'b1, 64'hD0, OKAY, 1'b0, 4'd4);
    #1;
    exp_r("t6.stall1", 1'b1, 64'hD0, OKAY, 1'b0, 4'd4);
    chk("t6.pkt_ready_stall", 64'(bus.pkt_ready), 64'd0);
    bus.r_ready = 1'b1;
    cyc();
    #1;
    chk("t6.pkt_ready_after_pop", 64'(bus.pkt_ready), 64'd1);
    exp_r("t6.beat1", 1'b1, 64'hD1, OKAY, 1'b0, 4'd4);
    cyc();
    bus.r_ready  = 1'b0;
    bus.pkt_data = 64'hD9;
    #1;
    chk("t6.pkt_ready_balanced", 64'(bus.pkt_ready), 64'd1);
    chk("t6.irq_balanced", 64'(bus.irq_vc), 64'h2);
    exp_r("t6.beat2", 1'b1, 64'hD2, OKAY, 1'b0, 4'd4);
    cyc();
    bus.pkt_valid = 1'b0;
    #1;
    chk("t6.pkt_ready_refull", 64'(bus.pkt_ready), 64'd0);
    exp_r("t6.beat2_held", 1'b1, 64'hD2, OKAY, 1'b0, 4'd4);
    bus.r_ready = 1'b1;
    arst_axi    = 1'b0;
    #1;
    chk_reset_outputs("t6.reset");
    @(posedge clk_axi);
    #2 arst_axi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk("t6.post_reset.r_valid",   64'(bus.r_valid),   64'd0);
      chk("t6.post_reset.irq_vc",    64'(bus.irq_vc),    64'd0);
      chk("t6.post_reset.pkt_ready", 64'(bus.pkt_ready), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
